// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle RV32 subset control FSM with retired-instruction counter
module control_fsm #(
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [2:0]  alu_control,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t      state_q, state_d;
    alu_op_t     alu_op_q, alu_op_d;
    logic        pc_write_q, pc_write_d;
    logic        branch_q, branch_d;
    logic        adr_src_q, adr_src_d;
    logic        mem_write_q, mem_write_d;
    logic        ir_write_q, ir_write_d;
    logic        reg_write_q, reg_write_d;
    logic [1:0]  result_src_q, result_src_d;
    logic [1:0]  alu_src_a_q, alu_src_a_d;
    logic [1:0]  alu_src_b_q, alu_src_b_d;
    logic        illegal_q, illegal_d;
    logic [31:0] instret_q, instret_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        pc_write_d   = 1'b0;
        branch_d     = 1'b0;
        adr_src_d    = 1'b0;
        mem_write_d  = 1'b0;
        ir_write_d   = 1'b0;
        reg_write_d  = 1'b0;
        result_src_d = 2'b00;
        alu_src_a_d  = 2'b00;
        alu_src_b_d  = 2'b00;
        alu_op_d     = ALU_ADD;
        case (state_d)
            S_FETCH: begin
                ir_write_d   = 1'b1;
                pc_write_d   = 1'b1;
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
            end
            S_MEMREAD:  adr_src_d = 1'b1;
            S_MEMWB: begin
                result_src_d = 2'b01;
                reg_write_d  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a_d = 2'b10;
                alu_op_d    = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
                alu_op_d    = ALU_FUNCT;
            end
            S_ALUWB:    reg_write_d = 1'b1;
            S_JAL: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b10;
                pc_write_d  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_d = 2'b10;
                alu_op_d    = ALU_SUB;
                branch_d    = 1'b1;
            end
            default: ;
        endcase
    end

    // A transition into FETCH from any other state marks one retired instruction.
    always_comb begin
        instret_d = instret_q;
        if (state_d == S_FETCH && state_q != S_FETCH) begin
            instret_d = instret_q + 32'd1;
        end
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FETCH;
            pc_write_q   <= 1'b1;
            branch_q     <= 1'b0;
            adr_src_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            ir_write_q   <= 1'b1;
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b10;
            alu_src_a_q  <= 2'b00;
            alu_src_b_q  <= 2'b10;
            alu_op_q     <= ALU_ADD;
            illegal_q    <= 1'b0;
            instret_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_write_q   <= pc_write_d;
            branch_q     <= branch_d;
            adr_src_q    <= adr_src_d;
            mem_write_q  <= mem_write_d;
            ir_write_q   <= ir_write_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            alu_op_q     <= alu_op_d;
            illegal_q    <= illegal_d;
            instret_q    <= instret_d;
        end
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (alu_op_q)
            ALU_SUB:   alu_control = 3'b001;
            ALU_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default:   alu_control = 3'b000;
        endcase
    end

    // BEQ's PC load follows the live zero flag rather than a registered copy.
    assign pc_write   = pc_write_q | (branch_q & zero);
    assign adr_src    = adr_src_q;
    assign mem_write  = mem_write_q;
    assign ir_write   = ir_write_q;
    assign reg_write  = reg_write_q;
    assign result_src = result_src_q;
    assign alu_src_a  = alu_src_a_q;
    assign alu_src_b  = alu_src_b_q;
    assign illegal    = illegal_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - table-driven and directed checks for control_fsm
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;

    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic [31:0] instret;

    logic        n_pc_write, n_adr_src, n_mem_write, n_ir_write, n_reg_write, n_illegal;
    logic [1:0]  n_result_src, n_alu_src_a, n_alu_src_b, n_imm_src;
    logic [2:0]  n_alu_control;
    logic [31:0] n_instret;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    control_fsm #(.TRAP_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal), .instret(instret)
    );

    control_fsm #(.TRAP_ILLEGAL(1'b0)) dut_noop (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .pc_write(n_pc_write), .adr_src(n_adr_src), .mem_write(n_mem_write), .ir_write(n_ir_write),
        .reg_write(n_reg_write), .result_src(n_result_src), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
        .imm_src(n_imm_src), .alu_control(n_alu_control), .illegal(n_illegal), .instret(n_instret)
    );

    // Packing: pw adr mw iw rw rs[2] a[2] b[2] imm[2] alu[3]
    localparam logic [15:0] FETCH  = 16'h9440;
    localparam logic [15:0] DECODE = 16'h00A0;
    localparam logic [15:0] MEMADR = 16'h0120;
    localparam logic [15:0] MEMRD  = 16'h4000;
    localparam logic [15:0] MEMWB  = 16'h0A00;
    localparam logic [15:0] MEMWR  = 16'h6000;
    localparam logic [15:0] EXECR  = 16'h0100;
    localparam logic [15:0] EXECI  = 16'h0120;
    localparam logic [15:0] ALUWB  = 16'h0800;
    localparam logic [15:0] JAL    = 16'h80C0;
    localparam logic [15:0] BEQ0   = 16'h0100;
    localparam logic [15:0] BEQ1   = 16'h8100;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [15:0] outs;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] dut_outs();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control};
    endfunction

    function automatic logic [15:0] noop_outs();
        return {n_pc_write, n_adr_src, n_mem_write, n_ir_write, n_reg_write, n_result_src,
                n_alu_src_a, n_alu_src_b, n_imm_src, n_alu_control};
    endfunction

    task automatic add_row(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                           input logic [15:0] base, input logic [1:0] imm, input logic [2:0] alu,
                           input logic [31:0] ir);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.z = z;
        v.outs = base | {11'd0, imm, alu};
        v.ir = ir;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; op = R; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;

        // add
        add_row(R, 3'b000, 0, 0, DECODE, 2'b00, 3'b000, 0);
        add_row(R, 3'b000, 0, 0, EXECR,  2'b00, 3'b000, 0);
        add_row(R, 3'b000, 0, 0, ALUWB,  2'b00, 3'b000, 0);
        add_row(R, 3'b000, 0, 0, FETCH,  2'b00, 3'b000, 1);
        // sub
        add_row(R, 3'b000, 1, 0, DECODE, 2'b00, 3'b000, 1);
        add_row(R, 3'b000, 1, 0, EXECR,  2'b00, 3'b001, 1);
        add_row(R, 3'b000, 1, 0, ALUWB,  2'b00, 3'b000, 1);
        add_row(R, 3'b000, 1, 0, FETCH,  2'b00, 3'b000, 2);
        // lw
        add_row(LW, 3'b010, 0, 0, DECODE, 2'b00, 3'b000, 2);
        add_row(LW, 3'b010, 0, 0, MEMADR, 2'b00, 3'b000, 2);
        add_row(LW, 3'b010, 0, 0, MEMRD,  2'b00, 3'b000, 2);
        add_row(LW, 3'b010, 0, 0, MEMWB,  2'b00, 3'b000, 2);
        add_row(LW, 3'b010, 0, 0, FETCH,  2'b00, 3'b000, 3);
        // sw
        add_row(SW, 3'b010, 0, 0, DECODE, 2'b01, 3'b000, 3);
        add_row(SW, 3'b010, 0, 0, MEMADR, 2'b01, 3'b000, 3);
        add_row(SW, 3'b010, 0, 0, MEMWR,  2'b01, 3'b000, 3);
        add_row(SW, 3'b010, 0, 0, FETCH,  2'b01, 3'b000, 4);
        // beq taken / not taken
        add_row(BQ, 3'b000, 0, 1, DECODE, 2'b10, 3'b000, 4);
        add_row(BQ, 3'b000, 0, 1, BEQ1,   2'b10, 3'b001, 4);
        add_row(BQ, 3'b000, 0, 1, FETCH,  2'b10, 3'b000, 5);
        add_row(BQ, 3'b000, 0, 0, DECODE, 2'b10, 3'b000, 5);
        add_row(BQ, 3'b000, 0, 0, BEQ0,   2'b10, 3'b001, 5);
        add_row(BQ, 3'b000, 0, 0, FETCH,  2'b10, 3'b000, 6);
        // jal counts once
        add_row(JL, 3'b000, 0, 0, DECODE, 2'b11, 3'b000, 6);
        add_row(JL, 3'b000, 0, 0, JAL,    2'b11, 3'b000, 6);
        add_row(JL, 3'b000, 0, 0, ALUWB,  2'b11, 3'b000, 6);
        add_row(JL, 3'b000, 0, 0, FETCH,  2'b11, 3'b000, 7);
        // addi with funct7b5 set stays add
        add_row(I, 3'b000, 1, 0, DECODE, 2'b00, 3'b000, 7);
        add_row(I, 3'b000, 1, 0, EXECI,  2'b00, 3'b000, 7);
        add_row(I, 3'b000, 1, 0, ALUWB,  2'b00, 3'b000, 7);
        add_row(I, 3'b000, 1, 0, FETCH,  2'b00, 3'b000, 8);
        // slti, or, and, unsupported funct3
        add_row(I, 3'b010, 0, 0, DECODE, 2'b00, 3'b000, 8);
        add_row(I, 3'b010, 0, 0, EXECI,  2'b00, 3'b101, 8);
        add_row(I, 3'b010, 0, 0, ALUWB,  2'b00, 3'b000, 8);
        add_row(I, 3'b010, 0, 0, FETCH,  2'b00, 3'b000, 9);
        add_row(R, 3'b110, 0, 0, DECODE, 2'b00, 3'b000, 9);
        add_row(R, 3'b110, 0, 0, EXECR,  2'b00, 3'b011, 9);
        add_row(R, 3'b110, 0, 0, ALUWB,  2'b00, 3'b000, 9);
        add_row(R, 3'b110, 0, 0, FETCH,  2'b00, 3'b000, 10);
        add_row(R, 3'b111, 0, 0, DECODE, 2'b00, 3'b000, 10);
        add_row(R, 3'b111, 0, 0, EXECR,  2'b00, 3'b010, 10);
        add_row(R, 3'b111, 0, 0, ALUWB,  2'b00, 3'b000, 10);
        add_row(R, 3'b111, 0, 0, FETCH,  2'b00, 3'b000, 11);
        add_row(R, 3'b001, 1, 0, DECODE, 2'b00, 3'b000, 11);
        add_row(R, 3'b001, 1, 0, EXECR,  2'b00, 3'b000, 11);
        add_row(R, 3'b001, 1, 0, ALUWB,  2'b00, 3'b000, 11);
        add_row(R, 3'b001, 1, 0, FETCH,  2'b00, 3'b000, 12);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {16'd0, dut_outs()}, {16'd0, FETCH});
        check("reset_instret", instret, 32'd0);
        check("reset_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7; zero = vecs[i].z;
            step();
            check($sformatf("row%0d_outs", i), {16'd0, dut_outs()}, {16'd0, vecs[i].outs});
            check($sformatf("row%0d_instret", i), instret, vecs[i].ir);
        end

        // Unknown opcode traps and holds until reset
        op = BAD; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
        step();
        check("bad_decode", {16'd0, dut_outs()}, {16'd0, DECODE});
        step();
        check("illegal_outs", {16'd0, dut_outs()}, 32'd0);
        check("illegal_flag", {31'd0, illegal}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("illegal_hold%0d", c),
                  {27'd0, pc_write, ir_write, mem_write, reg_write, illegal}, 32'd1);
        end
        check("illegal_instret", instret, 32'd12);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("illegal_rst_outs", {16'd0, dut_outs()}, {16'd0, FETCH});
        check("illegal_rst_flag", {31'd0, illegal}, 32'd0);
        check("illegal_rst_instret", instret, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Unknown opcode as a retired no-op when trapping is disabled
        step();
        check("noop_decode", {16'd0, noop_outs()}, {16'd0, DECODE});
        step();
        check("noop_fetch", {16'd0, noop_outs()}, {16'd0, FETCH});
        check("noop_instret", n_instret, 32'd1);
        check("noop_illegal", {31'd0, n_illegal}, 32'd0);
        check("trap_illegal", {31'd0, illegal}, 32'd1);

        // Reset during MEMWRITE drops the strobe without waiting for a clock
        @(negedge clk);
        reset_n = 1'b0;
        op = SW; zero = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("sw_decode", {16'd0, dut_outs()}, {16'd0, DECODE | 16'h0008});
        step();
        step();
        check("sw_memwrite", {16'd0, dut_outs()}, {16'd0, MEMWR | 16'h0008});
        #2;
        reset_n = 1'b0;
        #1;
        check("sw_rst_memwrite", {31'd0, mem_write}, 32'd0);
        check("sw_rst_outs", {16'd0, dut_outs()}, {16'd0, FETCH | 16'h0008});
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("sw_rst_first_fetch", {16'd0, dut_outs()}, {16'd0, DECODE | 16'h0008});

        // instret wraps from all-ones to zero
        @(negedge clk);
        reset_n = 1'b0;
        op = R; funct3 = 3'b000; funct7b5 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("wrap_preload", instret, 32'hFFFF_FFFF);
        repeat (3) step();
        check("wrap_hold", instret, 32'hFFFF_FFFF);
        step();
        check("wrap_zero", instret, 32'd0);
        check("wrap_fetch", {16'd0, dut_outs()}, {16'd0, FETCH});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
